fe_pow_seq: RTL and testbench

- Sequencer that drives the shared pipelined GF(2^255-19) multiplier as its initiator.
- Computes a field inversion a^(p-2), p = 2^255-19, by left-to-right square-and-multiply over a hard-coded exponent.
- Issues one multiply at a time, captures the reduced product after a fixed pipeline latency, and returns the final result with a done pulse.
- Sits between the point-arithmetic controller and the multiplier; used for projective-to-affine conversion before encoding.

---
 rtl/fe_pow_seq.sv | 154 +++++++++++++++
 tb/tb_fe_pow_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fe_pow_seq.sv
// Left-to-right square-and-multiply exponentiation over GF(2^255-19), acting as initiator of a pipelined multiplier.
// Define FE_POW_SQRT_EN to add op_sel, which selects the (p-5)/8 exponent used by square-root extraction.

module fe_pow_seq #(
  parameter int MULT_LAT = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
`ifdef FE_POW_SQRT_EN
  input  logic         op_sel,
`endif
  input  logic [254:0] in_a,
  output logic         busy,
  output logic         done,
  output logic [254:0] result,
  output logic [255:0] mult_a,
  output logic [255:0] mult_b,
  output logic         mult_ce,
  input  logic [254:0] mult_res
);

  localparam int CW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MULT_LAT - 1);

  // p-2: every bit set except bits 4 and 2; the MSB is folded into the initial acc=a.
  localparam logic [254:0] E_INV   = ~((255'd1 << 4) | (255'd1 << 2));
  localparam logic [7:0]   IDX_INV = 8'd253;
`ifdef FE_POW_SQRT_EN
  localparam logic [254:0] E_SQRT   = (255'd1 << 252) - 255'd3;
  localparam logic [7:0]   IDX_SQRT = 8'd250;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [254:0]    base_q, base_d;
  logic [254:0]    acc_q, acc_d;
  logic [254:0]    result_q, result_d;
  logic [7:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            op_mul_q, op_mul_d;
  logic            exp_bit;
  logic            active;
`ifdef FE_POW_SQRT_EN
  logic            op_sel_q, op_sel_d;

  assign exp_bit = op_sel_q ? E_SQRT[idx_q] : E_INV[idx_q];
`else
  assign exp_bit = E_INV[idx_q];
`endif

  // Operands are decoded from registered state, so they are stable for the whole op.
  always_comb begin
    active  = (state_q == S_ISSUE) || (state_q == S_WAIT);
    busy    = active;
    mult_ce = active;
    done    = (state_q == S_DONE);
    result  = result_q;
    mult_a  = active ? {1'b0, acc_q} : 256'd0;
    mult_b  = !active ? 256'd0 : (op_mul_q ? {1'b0, base_q} : {1'b0, acc_q});
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d  = state_q;
    base_d   = base_q;
    acc_d    = acc_q;
    result_d = result_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    op_mul_d = op_mul_q;
`ifdef FE_POW_SQRT_EN
    op_sel_d = op_sel_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d   = in_a;
          acc_d    = in_a;
          op_mul_d = 1'b0;
`ifdef FE_POW_SQRT_EN
          op_sel_d = op_sel;
          idx_d    = op_sel ? IDX_SQRT : IDX_INV;
`else
          idx_d    = IDX_INV;
`endif
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          acc_d = mult_res;
          if (!op_mul_q && exp_bit) begin
            op_mul_d = 1'b1;
            state_d  = S_ISSUE;
          end else if (idx_q == 8'd0) begin
            result_d = mult_res;
            state_d  = S_DONE;
          end else begin
            idx_d    = idx_q - 8'd1;
            op_mul_d = 1'b0;
            state_d  = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      op_mul_q <= 1'b0;
`ifdef FE_POW_SQRT_EN
      op_sel_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      op_mul_q <= op_mul_d;
`ifdef FE_POW_SQRT_EN
      op_sel_q <= op_sel_d;
`endif
    end
  end

endmodule

// File: tb/tb_fe_pow_seq.sv
// Directed bench for fe_pow_seq with a behavioural MULT_LAT-stage GF(2^255-19) multiplier.
// Define FE_POW_SQRT_EN on both files to exercise the square-root exponent.

module tb_fe_pow_seq;

  localparam int MULT_LAT = 7;
  localparam int LAT_INV  = 506 * (MULT_LAT + 1) + 1;
  localparam logic [255:0] P = (256'd1 << 255) - 256'd19;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic [254:0] in_a  = '0;
  logic         busy;
  logic         done;
  logic [254:0] result;
  logic [255:0] mult_a;
  logic [255:0] mult_b;
  logic         mult_ce;
  logic [254:0] mult_res;
  logic [254:0] pipe [MULT_LAT];
`ifdef FE_POW_SQRT_EN
  logic         op_sel = 1'b0;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  fe_pow_seq #(.MULT_LAT(MULT_LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
`ifdef FE_POW_SQRT_EN
    .op_sel   (op_sel),
`endif
    .in_a     (in_a),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .mult_a   (mult_a),
    .mult_b   (mult_b),
    .mult_ce  (mult_ce),
    .mult_res (mult_res)
  );

  function automatic logic [254:0] fmul(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] prod;
    prod = {256'd0, a} * {256'd0, b};
    prod = prod % {256'd0, P};
    return prod[254:0];
  endfunction

  // Multiplier model: product of the operands seen at an edge appears MULT_LAT edges later; never flushed.
  always @(posedge clk) begin
    pipe[0] <= fmul(mult_a, mult_b);
    for (int i = 1; i < MULT_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mult_res = pipe[MULT_LAT-1];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; start is accepted at the next posedge.
  task automatic run(input logic [254:0] a, input logic [254:0] exp, input int lat,
                     input string tag, input int restart_at);
    int n;
    int ce_cnt;
    int busy_cnt;
    bit seen;
    in_a  = a;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    in_a     = ~a;
    n        = 1;
    ce_cnt   = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (n < lat + 20) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (mult_ce) ce_cnt++;
      if (busy) busy_cnt++;
      start = (n == restart_at);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 256'(seen), 256'd1);
    check({tag, "_latency"}, 256'(n), 256'(lat));
    check({tag, "_result"}, {1'b0, result}, {1'b0, exp});
    check({tag, "_busy_cycles"}, 256'(busy_cnt), 256'(lat - 1));
    check({tag, "_ce_cycles"}, 256'(ce_cnt), 256'(lat - 1));
    check({tag, "_busy_at_done"}, 256'(busy), 256'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 256'(done), 256'd0);
    check({tag, "_result_hold"}, {1'b0, result}, {1'b0, exp});
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 256'(busy), 256'd0);
    check({tag, "_done"}, 256'(done), 256'd0);
    check({tag, "_ce"}, 256'(mult_ce), 256'd0);
    check({tag, "_mult_a"}, mult_a, 256'd0);
    check({tag, "_mult_b"}, mult_b, 256'd0);
  endtask

`ifdef FE_POW_SQRT_EN
  function automatic logic [254:0] fpow(input logic [254:0] a, input logic [254:0] e);
    logic [254:0] r;
    r = 255'd1;
    for (int i = 254; i >= 0; i--) begin
      r = fmul({1'b0, r}, {1'b0, r});
      if (e[i]) r = fmul({1'b0, r}, {1'b0, a});
    end
    return r;
  endfunction
`endif

  initial begin
    logic [254:0] inv2;
    logic [254:0] inv3;
    logic [254:0] pm1;
    int dones;
    logic [255:0] third;
    inv2  = 255'((256'd1 << 254) - 256'd9);
    third = {32{8'h55}} - 256'd12;
    inv3  = third[254:0];
    pm1   = 255'(P - 256'd1);

    #1 rst = 1'b0;
    @(negedge clk);
    check_quiet("reset");
    check("reset_result", {1'b0, result}, 256'd0);
    rst = 1'b1;
    @(negedge clk);

    run(255'd1, 255'd1, LAT_INV, "inv1", -1);
    run(255'd2, inv2, LAT_INV, "inv2", -1);
    run(pm1, pm1, LAT_INV, "inv_pm1", -1);
    run(255'd3, inv3, LAT_INV, "inv3_b2b", -1);
    run(255'd0, 255'd0, LAT_INV, "inv0_restart", 100);

    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) dones++;
      @(negedge clk);
    end
    check("inv0_no_requeue", 256'(dones), 256'd0);

    in_a  = 255'd5;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    check("pre_reset_busy", 256'(busy), 256'd1);
    #2 rst = 1'b0;
    #1;
    check_quiet("midrst");
    check("midrst_result", {1'b0, result}, 256'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run(255'd2, inv2, LAT_INV, "post_rst_inv2", -1);

`ifdef FE_POW_SQRT_EN
    op_sel = 1'b1;
    run(255'd4, fpow(255'd4, (255'd1 << 252) - 255'd3), 501 * (MULT_LAT + 1) + 1, "sqrt4", -1);
    op_sel = 1'b0;
    run(255'd2, inv2, LAT_INV, "sel0_inv2", -1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
